// File: rtl/npn_canon_engine.sv
// -----------------------------------------------------------------------------
// npn_canon_engine
//
// Sequential NPN canonicaliser for single-output Boolean functions of N_IN
// inputs given as truth tables. Every transform (permutation p, input-negation
// mask m, output negation o) is evaluated in turn, one per clock. The engine
// returns the numerically smallest transformed table and the earliest
// transform that produced it. The result is the lookup key for the per-class
// AIG library.
//
// Transform: g[x] = o ^ f[y], where y_j = x_{p(j)} ^ m_j.
// Enumeration order: k = (perm * 2^N_IN + mask) * 2 + oneg, with perm
// outermost. Permutations are numbered in lexicographic order of
// (p(0), ..., p(N_IN-1)).
//
// Optional build macro:
//   NPN_CANON_EARLY_EXIT_EN - finish as soon as the best table becomes
//                             all-zero, which is the global minimum.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   engine idle, a request is accepted
//   in_tt      input truth table; bit i = f(x), where x_j = bit j of i
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_tt     canonical truth table
//   out_perm   permutation index of the winning transform
//   out_mask   input-negation mask of the winning transform
//   out_oneg   output negation of the winning transform
//   busy       high while searching or holding a result
// -----------------------------------------------------------------------------
module npn_canon_engine #(
    parameter int N_IN   = 4,
    parameter int TT_W   = 2**N_IN,
    parameter int PERM_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TT_W-1:0]   in_tt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TT_W-1:0]   out_tt,
    output logic [PERM_W-1:0] out_perm,
    output logic [N_IN-1:0]   out_mask,
    output logic              out_oneg,
    output logic              busy
);

    function automatic int fact(input int n);
        int r;
        r = 1;
        for (int i = 2; i <= n; i++) begin
            r = r * i;
        end
        return r;
    endfunction

    localparam int NFACT = fact(N_IN);
    localparam int DW    = 3;        // holds digits and element numbers up to 4
    localparam int XW    = 1 << DW;  // bit vectors indexed by a DW-bit value

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]                 state_r, state_nx_s;
    logic [TT_W-1:0]            f_r;
    logic [TT_W-1:0]            best_tt_r;
    logic [PERM_W-1:0]          best_perm_r;
    logic [N_IN-1:0]            best_mask_r;
    logic                       best_oneg_r;
    logic                       in_ready_r, out_valid_r, busy_r;

    // Transform counters. The permutation is tracked both as its index, which
    // is reported, and as factorial-base (Lehmer) digits, which decode
    // directly into the permutation tuple.
    logic [PERM_W-1:0]          perm_idx_r, perm_nx_s;
    logic [N_IN-1:0][DW-1:0]    digit_r, digit_nx_s;
    logic [N_IN-1:0]            mask_r, mask_nx_s;
    logic                       oneg_r, oneg_nx_s;
    logic                       carry_s;

    logic [N_IN-1:0][DW-1:0]    perm_s;
    logic [XW-1:0]              used_s;
    logic [DW-1:0]              cnt_s, sel_s;
    logic [XW-1:0]              xv_s;
    logic [N_IN-1:0]            y_s;
    logic [TT_W-1:0]            g_s;
    logic                       k_first_s, k_last_s, best_upd_s, search_end_s;

    // Decode the Lehmer digits: p(i) is the digit_r[i]-th still-unused input.
    always_comb begin
        used_s = '0;
        perm_s = '0;
        cnt_s  = '0;
        sel_s  = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt_s = '0;
            sel_s = '0;
            for (int c = 0; c < N_IN; c++) begin
                if (!used_s[c]) begin
                    if (cnt_s == digit_r[i]) begin
                        sel_s = DW'(c);
                    end else begin
                        sel_s = sel_s;
                    end
                    cnt_s = cnt_s + DW'(1);
                end else begin
                    cnt_s = cnt_s;
                end
            end
            perm_s[i]     = sel_s;
            used_s[sel_s] = 1'b1;
        end
    end

    // Apply the current transform to the latched function.
    always_comb begin
        g_s  = '0;
        xv_s = '0;
        y_s  = '0;
        for (int x = 0; x < TT_W; x++) begin
            xv_s = XW'(x);
            for (int j = 0; j < N_IN; j++) begin
                y_s[j] = xv_s[perm_s[j]] ^ mask_r[j];
            end
            g_s[x] = oneg_r ^ f_r[y_s];
        end
    end

    // Step to the next transform: oneg is innermost, then mask, then perm.
    always_comb begin
        oneg_nx_s  = ~oneg_r;
        mask_nx_s  = mask_r;
        perm_nx_s  = perm_idx_r;
        digit_nx_s = digit_r;
        carry_s    = 1'b0;
        if (oneg_r) begin
            mask_nx_s = mask_r + N_IN'(1);
            if (&mask_r) begin
                perm_nx_s = perm_idx_r + PERM_W'(1);
                carry_s   = 1'b1;
                // Mixed-radix increment: digit i counts 0..N_IN-1-i.
                for (int i = N_IN - 1; i >= 0; i--) begin
                    if (carry_s) begin
                        if (digit_r[i] == DW'(N_IN - 1 - i)) begin
                            digit_nx_s[i] = '0;
                        end else begin
                            digit_nx_s[i] = digit_r[i] + DW'(1);
                            carry_s       = 1'b0;
                        end
                    end else begin
                        digit_nx_s[i] = digit_r[i];
                    end
                end
            end else begin
                perm_nx_s = perm_idx_r;
            end
        end else begin
            mask_nx_s = mask_r;
        end
    end

    // Best-candidate update and end-of-search detection.
    always_comb begin
        k_first_s  = (perm_idx_r == '0) && (mask_r == '0) && !oneg_r;
        k_last_s   = (perm_idx_r == PERM_W'(NFACT - 1)) && (&mask_r) && oneg_r;
        // Strict compare keeps the earliest transform on ties.
        best_upd_s = (state_r == ST_SEARCH) && (k_first_s || (g_s < best_tt_r));
`ifdef NPN_CANON_EARLY_EXIT_EN
        search_end_s = k_last_s || (best_upd_s && (g_s == '0));
`else
        search_end_s = k_last_s;
`endif
    end

    // Next-state logic of the IDLE -> SEARCH -> DONE controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_SEARCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (search_end_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SEARCH;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, handshake flags, latched function, counters and best result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            f_r         <= '0;
            best_tt_r   <= '0;
            best_perm_r <= '0;
            best_mask_r <= '0;
            best_oneg_r <= 1'b0;
            perm_idx_r  <= '0;
            digit_r     <= '0;
            mask_r      <= '0;
            oneg_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
            if ((state_r == ST_IDLE) && in_valid) begin
                f_r        <= in_tt;
                perm_idx_r <= '0;
                digit_r    <= '0;
                mask_r     <= '0;
                oneg_r     <= 1'b0;
            end else if (state_r == ST_SEARCH) begin
                perm_idx_r <= perm_nx_s;
                digit_r    <= digit_nx_s;
                mask_r     <= mask_nx_s;
                oneg_r     <= oneg_nx_s;
                if (best_upd_s) begin
                    best_tt_r   <= g_s;
                    best_perm_r <= perm_idx_r;
                    best_mask_r <= mask_r;
                    best_oneg_r <= oneg_r;
                end else begin
                    best_tt_r   <= best_tt_r;
                end
            end else begin
                f_r <= f_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_tt    = best_tt_r;
    assign out_perm  = best_perm_r;
    assign out_mask  = best_mask_r;
    assign out_oneg  = best_oneg_r;

endmodule
